// File: rtl/dequantizer.sv
// rtl/dequantizer.sv - 2-stage JPEG-style coefficient dequantizer with a 64-entry table.
// Optional DEQUANTIZER_SAT_EN: saturate the product instead of wrapping it.
`timescale 1ns/1ps
module dequantizer #(
    parameter int COEF_BITWIDTH = 12,
    parameter int QTAB_BITWIDTH = 8,
    parameter int DCT_BITWIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     qt_we,
    input  logic [5:0]               qt_addr,
    input  logic [QTAB_BITWIDTH-1:0] qt_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [COEF_BITWIDTH-1:0] s_data,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DCT_BITWIDTH-1:0]  m_data,
    output logic [5:0]               m_index,
    output logic                     m_last,
    output logic                     frame_err
);
    localparam int PW = COEF_BITWIDTH + QTAB_BITWIDTH + 1;

    logic [QTAB_BITWIDTH-1:0] qtab [64];
    logic [5:0]               cnt;
    logic                     s1_valid;
    logic signed [PW-1:0]     s1_prod;
    logic [5:0]               s1_index;
    logic                     enable;
    logic                     accept;
    logic signed [PW-1:0]     coef_ext;
    logic signed [PW-1:0]     qent_ext;
    logic signed [PW-1:0]     product;
    logic [DCT_BITWIDTH-1:0]  limited;

    assign enable  = !m_valid || m_ready;
    assign s_ready = enable;
    assign accept  = s_valid && enable;

    // Table entry is zero-extended so 255 stays positive in the signed multiply.
    assign coef_ext = {{(QTAB_BITWIDTH+1){s_data[COEF_BITWIDTH-1]}}, s_data};
    assign qent_ext = {{(COEF_BITWIDTH+1){1'b0}}, qtab[cnt]};
    assign product  = coef_ext * qent_ext;

`ifdef DEQUANTIZER_SAT_EN
    localparam logic signed [PW-1:0] SAT_MAX =
        {{(PW-DCT_BITWIDTH+1){1'b0}}, {(DCT_BITWIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN =
        {{(PW-DCT_BITWIDTH+1){1'b1}}, {(DCT_BITWIDTH-1){1'b0}}};

    always_comb begin
        limited = s1_prod[DCT_BITWIDTH-1:0];
        if (s1_prod > SAT_MAX) begin
            limited = SAT_MAX[DCT_BITWIDTH-1:0];
        end else if (s1_prod < SAT_MIN) begin
            limited = SAT_MIN[DCT_BITWIDTH-1:0];
        end
    end
`else
    logic unused_prod_hi;
    assign unused_prod_hi = ^s1_prod[PW-1:DCT_BITWIDTH];

    always_comb begin
        limited = s1_prod[DCT_BITWIDTH-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                qtab[i] <= QTAB_BITWIDTH'(1);
            end
            cnt       <= 6'd0;
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_index  <= 6'd0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_index   <= 6'd0;
            m_last    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Lookup above reads the pre-write entry, so a same-cycle write lands on the next beat.
            if (qt_we) begin
                qtab[qt_addr] <= qt_data;
            end
            if (accept) begin
                cnt <= s_last ? 6'd0 : cnt + 6'd1;
                if (s_last != (cnt == 6'd63)) begin
                    frame_err <= 1'b1;
                end
            end
            if (enable) begin
                s1_valid <= s_valid;
                s1_prod  <= product;
                s1_index <= cnt;
                m_valid  <= s1_valid;
                m_data   <= limited;
                m_index  <= s1_index;
                m_last   <= (s1_index == 6'd63);
            end
        end
    end
endmodule

// File: tb/tb_dequantizer.sv
// tb/tb_dequantizer.sv - randomized scoreboard bench for dequantizer.
`timescale 1ns/1ps
module tb_dequantizer;
    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        rst, qt_we, s_valid, s_ready, s_last, m_valid, m_ready, m_last, frame_err;
    logic [5:0]  qt_addr, m_index;
    logic [7:0]  qt_data;
    logic [11:0] s_data;
    logic [15:0] m_data;

    dequantizer dut (
        .clk(clk), .rst(rst), .qt_we(qt_we), .qt_addr(qt_addr), .qt_data(qt_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {int data; int idx; bit last;} beat_t;

    int    n_tests = 0, n_fail = 0;
    beat_t q[$];
    int    mtab [64];
    int    mcnt = 0, cyc = 0, lat_start = -1, last_idx = -1, outs = 0, accs = 0;
    int    log_data [64];
    bit    mferr = 0, prev_rst = 0, seen_rst = 0, lat_armed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int limit(input longint p);
`ifdef DEQUANTIZER_SAT_EN
        if (p > (64'sd1 <<< (DB-1)) - 1) return (1 << (DB-1)) - 1;
        if (p < -(64'sd1 <<< (DB-1))) return -(1 << (DB-1));
        return int'(p);
`else
        logic [DB-1:0] t;
        t = p[DB-1:0];
        return int'($signed(t));
`endif
    endfunction

    // Compare first (against state as of the last edge), then fold in what the next edge accepts.
    always @(negedge clk) begin
        cyc++;
        if (seen_rst) begin
            if (prev_rst) begin
                check("rst_m_valid", m_valid, 0);
                check("rst_frame_err", frame_err, 0);
            end
            check("s_ready", s_ready, (!m_valid || m_ready));
            check("frame_err", frame_err, mferr);
            if (m_valid) begin
                if (q.size() == 0) begin
                    check("spurious_beat", 1, 0);
                end else begin
                    check("m_data", longint'($signed(m_data)), q[0].data);
                    check("m_index", m_index, q[0].idx);
                    check("m_last", m_last, q[0].last);
                    if (m_ready) begin
                        log_data[m_index] = int'($signed(m_data));
                        last_idx = m_index;
                        void'(q.pop_front());
                        outs++;
                    end
                end
                if (lat_armed && lat_start >= 0) begin
                    check("latency", cyc - lat_start, 2);
                    lat_armed = 0;
                end
            end
        end
        if (rst) begin
            q.delete();
            mcnt = 0; mferr = 0; outs = 0; accs = 0;
            for (int i = 0; i < 64; i++) mtab[i] = 1;
        end else begin
            if (s_valid && s_ready) begin
                q.push_back('{limit(longint'($signed(s_data)) * mtab[mcnt]), mcnt, (mcnt == 63)});
                if (s_last != (mcnt == 63)) mferr = 1;
                mcnt = s_last ? 0 : (mcnt + 1) % 64;
                if (lat_armed && lat_start < 0) lat_start = cyc;
                accs++;
            end
            if (qt_we) mtab[qt_addr] = qt_data;
        end
        if (prev_rst) seen_rst = 1;
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input bit l);
        bit acc;
        int g;
        acc = 0; g = 0;
        s_valid = 1; s_data = 12'(d); s_last = l;
        while (!acc && g < 200) begin
            @(negedge clk);
            acc = s_ready;
            tick();
            g++;
        end
        if (!acc) check("send_timeout", 0, 1);
        s_valid = 0;
    endtask

    task automatic write_tab(input int a, input int v);
        qt_we = 1; qt_addr = 6'(a); qt_data = 8'(v);
        tick();
        qt_we = 0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q.size() != 0 || m_valid) && g < 400) begin
            tick();
            g++;
        end
        check("drain_timeout", (g < 400), 1);
    endtask

    initial begin
        logic [15:0] held;
        bit done;
        rst = 1; qt_we = 0; qt_addr = 0; qt_data = 0;
        s_valid = 0; s_data = 0; s_last = 0; m_ready = 1;
        repeat (3) tick();
        rst = 0;
        check("reset_m_valid", m_valid, 0);
        check("reset_m_data", m_data, 0);
        check("reset_m_index", m_index, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_s_ready", s_ready, 1);

        // Identity table pass-through and 2-cycle latency.
        lat_start = -1; lat_armed = 1;
        for (int k = 0; k < 64; k++) send(k - 32, k == 63);
        drain();
        check("id_first", log_data[0], -32);
        check("id_mid", log_data[40], 8);
        check("id_last", log_data[63], 31);
        check("id_last_idx", last_idx, 63);
        check("latency_seen", lat_armed, 0);

        // Scaled and zeroed entries.
        write_tab(5, 16);
        write_tab(0, 0);
        for (int k = 0; k < 64; k++) send(-3, k == 63);
        drain();
        check("scale_idx5", log_data[5], -48);
        check("zero_idx0", log_data[0], 0);
        check("unit_idx6", log_data[6], -3);

        // Overflow product, and a table write colliding with the beat it addresses.
        write_tab(7, 255);
        for (int k = 0; k < 64; k++) begin
            if (k == 9) begin qt_we = 1; qt_addr = 9; qt_data = 3; end
            send((k == 7) ? 2047 : 10, k == 63);
            qt_we = 0;
        end
        drain();
`ifdef DEQUANTIZER_SAT_EN
        check("overflow_idx7", log_data[7], 32767);
`else
        check("overflow_idx7", log_data[7], -2303);
`endif
        check("collide_old_value", log_data[9], 10);
        for (int k = 0; k < 64; k++) send(10, k == 63);
        drain();
        check("collide_new_value", log_data[9], 30);
        check("scale_idx5_b", log_data[5], 160);

        // Backpressure for 4 cycles mid-stream.
        fork
            for (int k = 0; k < 64; k++) send(k * 7 - 200, k == 63);
            begin
                repeat (20) tick();
                m_ready = 0;
                tick();
                held = m_data;
                check("stall_s_ready", s_ready, 0);
                repeat (3) tick();
                check("stall_held", m_data, held);
                m_ready = 1;
            end
        join
        drain();
        check("no_loss_dup", outs, accs);

        // Early s_last: sticky error and counter restart.
        for (int k = 0; k <= 10; k++) send(k, k == 10);
        send(5, 0);
        drain();
        check("ferr_set", frame_err, 1);
        check("restart_idx", last_idx, 0);
        for (int k = 1; k < 64; k++) send(k, k == 63);
        drain();
        check("ferr_sticky", frame_err, 1);

        // Reset mid-block.
        for (int k = 0; k < 30; k++) send(k, 0);
        rst = 1;
        tick();
        check("midrst_m_valid", m_valid, 0);
        tick();
        rst = 0;
        check("midrst_frame_err", frame_err, 0);
        for (int k = 0; k < 64; k++) send(k + 1, k == 63);
        drain();
        check("midrst_idx0", log_data[0], 1);
        check("midrst_tab5", log_data[5], 6);
        check("midrst_tab9", log_data[9], 10);
        check("midrst_last_idx", last_idx, 63);

        // Randomized traffic with table writes and backpressure.
        done = 0;
        fork
            begin
                int dc;
                bit l;
                dc = 0;
                for (int n = 0; n < 1500; n++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        qt_we = 1; qt_addr = 6'($urandom); qt_data = 8'($urandom);
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        tick();
                    end else begin
                        l = (dc == 63);
                        if ($urandom_range(0, 59) == 0) l = !l;
                        send(int'($urandom_range(0, 4095)), l);
                        dc = l ? 0 : (dc + 1) % 64;
                    end
                    qt_we = 0;
                end
                done = 1;
            end
            begin
                while (!done) begin
                    m_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                m_ready = 1;
            end
        join
        drain();
        check("random_no_loss_dup", outs, accs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
